bp_me_nonsynth_multi_lce_test_monitor: RTL and testbench
========================================================

Name: bp_me_nonsynth_multi_lce_test_monitor

Overview:
Nonsynth end-of-test monitor for multi-LCE CCE benches. It replaces the single-LCE done/$finish logic with N channels.
- Latches a sticky done per trace-replay channel.
- Counts run cycles while unfrozen.
- Records per-channel completion cycle and per-channel activity counts.
- Runs a stall watchdog.
- Declares PASS when every channel is done, or FAIL on timeout.
Sits in the testbench beside the trace node masters, mock LCEs and cfg loader.

Parameters:
num_lce_p, 4, number of LCE/trace channels (>=1)
max_clock_cnt_p, 2**30-1, saturation value of the run-cycle counter
timeout_cycles_p, 1000000, consecutive no-progress run cycles before FAIL (>=1)
bytes_per_op_p, 64, bytes credited per activity pulse, used for the bandwidth report
cnt_width_lp, `BSG_SAFE_CLOG2(max_clock_cnt_p+1), localparam, counter width
stall_width_lp, `BSG_SAFE_CLOG2(timeout_cycles_p+1), localparam, stall counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
freeze_i  in  1  cfg bus freeze; counting enabled only when low
tr_done_i  in  num_lce_p  per-channel trace-replay done, level or pulse
activity_i  in  num_lce_p  per-channel progress pulse (trace packet consumed)
done_vec_o  out  num_lce_p  sticky per-channel done
clock_cnt_o  out  cnt_width_lp  run cycles elapsed
done_cycle_o  out  num_lce_p*cnt_width_lp  clock_cnt at each channel's first done; channel i occupies slice [i*cnt_width_lp +: cnt_width_lp]
op_cnt_o  out  num_lce_p*cnt_width_lp  per-channel activity count, saturating
pass_o  out  1  sticky, all channels done
timeout_o  out  1  sticky, watchdog fired
finish_o  out  1  one-cycle pulse on entry to a terminal state

Behaviour:
- Reset: all outputs 0, all counters 0, state e_idle. Reset asserted in any state, including mid-run or terminal, returns to this condition on the next edge.
- States: e_idle, e_run, e_pass, e_timeout.
  - e_idle -> e_run on the first cycle freeze_i=0.
  - e_run -> e_pass when the next-cycle done vector is all ones.
  - e_run -> e_timeout when stall_cnt == timeout_cycles_p-1 and no progress occurs this cycle.
  - Done and timeout in the same cycle: e_pass wins.
  - e_pass and e_timeout are sticky until reset; counters freeze there.
- Counting rule: counters advance only in e_run with freeze_i=0. freeze_i reasserted mid-run holds every counter and the state; no transition occurs while frozen.
- Done latching: done_vec_o[i] sets on the edge after tr_done_i[i]=1 in e_run (1-cycle latency) and never clears until reset. tr_done_i in e_idle is ignored.
- done_cycle: written with the current clock_cnt (pre-increment value) on the cycle done first sets; later tr_done_i has no effect.
- clock_cnt: +1 per counting cycle; saturates at max_clock_cnt_p with no wrap.
- op_cnt[i]: +1 per counting cycle with activity_i[i]=1, including after channel i is done; saturates at max_clock_cnt_p.
- Progress: any activity_i bit, or any newly set done bit, in a counting cycle. Progress clears stall_cnt to 0; otherwise stall_cnt increments.
- Simultaneous dones: all channels in the same cycle -> single transition to e_pass; done_cycle values are equal.
- pass_o/timeout_o assert on the same edge the state enters e_pass/e_timeout; finish_o is high for exactly that one cycle.
- Report on the finish_o cycle, at negedge:
  - PASS: print total bytes (sum op_cnt*bytes_per_op_p), clock_cnt and mBPC, then "Test PASSed".
  - TIMEOUT: print "Test FAILed: timeout" and done_vec_o.
  - mBPC uses a guarded divide; clock_cnt=0 reports 0.
  - The bench, not this block, calls $finish.

Decomposition:
- bp_me_nonsynth_pkg: bp_me_nonsynth_test_state_e enum (e_idle, e_run, e_pass, e_timeout).
- Sub-module bp_me_nonsynth_lce_done_tracker, instantiated num_lce_p times via generate. It holds the sticky done, done_cycle capture, saturating op counter and new-done pulse.
- Top holds the FSM, clock counter, stall watchdog and report.

Test Plan:
All scenarios use num_lce_p=2 and timeout_cycles_p=16.
- Reset then freeze_i=0 at cycle 5; tr_done_i[0] at run cycle 10 and tr_done_i[1] at run cycle 20 -> done_cycle {20,10}, pass_o rises 1 cycle after channel 1's done, finish_o one pulse, clock_cnt frozen at 21.
- Run with no activity or done -> timeout_o after exactly 16 run cycles; pass_o=0; finish_o single pulse.
- Activity pulse every 15 cycles for 100 cycles, then both dones -> no timeout, pass_o=1, op_cnt each 6 or 7 matching pulses driven.
- Both tr_done_i in the same cycle as stall_cnt reaches 15 -> pass_o=1, timeout_o=0.
- freeze_i=1 for 50 cycles mid-run -> clock_cnt and stall_cnt hold, no timeout; counting resumes on unfreeze.
- reset_i pulsed after pass -> all outputs 0, state e_idle; a second test then passes normally.

Source files
------------

// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the multi-LCE end-of-test monitor.
//   bp_me_nonsynth_test_state_e : monitor FSM state encoding
//   safe_clog2                  : counter width helper, never returns 0
package bp_me_nonsynth_pkg;

    typedef enum logic [1:0] {
        e_idle    = 2'd0,
        e_run     = 2'd1,
        e_pass    = 2'd2,
        e_timeout = 2'd3
    } bp_me_nonsynth_test_state_e;

    // Width needed to hold values 0..x-1, with a floor of one bit so a
    // degenerate parameter never yields a zero-width vector.
    function automatic int safe_clog2(input longint x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_me_nonsynth_lce_done_tracker.sv
// Per-channel bookkeeping for the end-of-test monitor.
//   clk_i        : clock
//   reset_i      : synchronous active-high reset
//   count_en_i   : high on cycles the monitor is running and unfrozen
//   tr_done_i    : trace-replay done for this channel (level or pulse)
//   activity_i   : progress pulse for this channel
//   clock_cnt_i  : current run-cycle count from the top
//   done_o       : sticky done
//   new_done_o   : done is being set this cycle (combinational)
//   done_cycle_o : clock_cnt_i captured when done first set
//   op_cnt_o     : saturating activity count
module bp_me_nonsynth_lce_done_tracker
    import bp_me_nonsynth_pkg::*;
#(
    parameter int cnt_width_p = 30,
    parameter int max_cnt_p   = 2**30 - 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   count_en_i,
    input  logic                   tr_done_i,
    input  logic                   activity_i,
    input  logic [cnt_width_p-1:0] clock_cnt_i,
    output logic                   done_o,
    output logic                   new_done_o,
    output logic [cnt_width_p-1:0] done_cycle_o,
    output logic [cnt_width_p-1:0] op_cnt_o
);

    localparam logic [cnt_width_p-1:0] max_cnt_lp = cnt_width_p'(max_cnt_p);

    logic                   done_r;
    logic [cnt_width_p-1:0] done_cycle_r;
    logic [cnt_width_p-1:0] op_cnt_r;

    // Only the first done in a counting cycle matters; later ones are masked
    // so done_cycle keeps the original completion time.
    assign new_done_o = count_en_i & tr_done_i & ~done_r;

    // NOTE: state registers use non-blocking assignments so every flop in the
    // block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_r       <= 1'b0;
            done_cycle_r <= '0;
            op_cnt_r     <= '0;
        end else if (count_en_i) begin
            if (new_done_o) begin
                done_r       <= 1'b1;
                done_cycle_r <= clock_cnt_i;
            end
            // Activity keeps counting after done so late traffic still shows
            // up in the bandwidth figure.
            if (activity_i && (op_cnt_r != max_cnt_lp)) begin
                op_cnt_r <= op_cnt_r + 1'b1;
            end
        end
    end

    assign done_o       = done_r;
    assign done_cycle_o = done_cycle_r;
    assign op_cnt_o     = op_cnt_r;

endmodule

// File: rtl/bp_me_nonsynth_multi_lce_test_monitor.sv
// End-of-test monitor for multi-LCE CCE benches. Tracks per-channel done and
// activity, counts unfrozen run cycles, runs a stall watchdog and declares
// pass (all channels done) or timeout. The surrounding bench calls $finish.
//   clk_i        : clock
//   reset_i      : synchronous active-high reset
//   freeze_i     : cfg freeze; counting only while low
//   tr_done_i    : per-channel trace-replay done
//   activity_i   : per-channel progress pulse
//   done_vec_o   : sticky per-channel done
//   clock_cnt_o  : run cycles elapsed (saturating)
//   done_cycle_o : per-channel completion cycle, channel i at [i*W +: W]
//   op_cnt_o     : per-channel activity count, channel i at [i*W +: W]
//   pass_o       : sticky, all channels done
//   timeout_o    : sticky, watchdog fired
//   finish_o     : one-cycle pulse on entry to pass or timeout
module bp_me_nonsynth_multi_lce_test_monitor
    import bp_me_nonsynth_pkg::*;
#(
    parameter int num_lce_p        = 4,
    parameter int max_clock_cnt_p  = 2**30 - 1,
    parameter int timeout_cycles_p = 1000000,
    parameter int bytes_per_op_p   = 64,
    parameter bit report_p         = 1'b1,
    localparam int cnt_width_lp    = safe_clog2(longint'(max_clock_cnt_p) + 1),
    localparam int stall_width_lp  = safe_clog2(longint'(timeout_cycles_p) + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              freeze_i,
    input  logic [num_lce_p-1:0]              tr_done_i,
    input  logic [num_lce_p-1:0]              activity_i,
    output logic [num_lce_p-1:0]              done_vec_o,
    output logic [cnt_width_lp-1:0]           clock_cnt_o,
    output logic [num_lce_p*cnt_width_lp-1:0] done_cycle_o,
    output logic [num_lce_p*cnt_width_lp-1:0] op_cnt_o,
    output logic                              pass_o,
    output logic                              timeout_o,
    output logic                              finish_o
);

    localparam logic [cnt_width_lp-1:0]   max_cnt_lp    = cnt_width_lp'(max_clock_cnt_p);
    localparam logic [stall_width_lp-1:0] stall_last_lp = stall_width_lp'(timeout_cycles_p - 1);

    bp_me_nonsynth_test_state_e state_r;
    logic [cnt_width_lp-1:0]    clock_cnt_r;
    logic [stall_width_lp-1:0]  stall_cnt_r;
    logic                       pass_r;
    logic                       timeout_r;
    logic                       finish_r;

    logic                       counting;
    logic [num_lce_p-1:0]       done_vec;
    logic [num_lce_p-1:0]       new_done_vec;
    logic                       all_done_next;
    logic                       progress;
    logic [cnt_width_lp-1:0]    op_cnt_w [num_lce_p];

    assign counting = (state_r == e_run) && !freeze_i;

    for (genvar i = 0; i < num_lce_p; i++) begin : g_lce
        bp_me_nonsynth_lce_done_tracker #(
            .cnt_width_p (cnt_width_lp),
            .max_cnt_p   (max_clock_cnt_p)
        ) u_tracker (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .count_en_i   (counting),
            .tr_done_i    (tr_done_i[i]),
            .activity_i   (activity_i[i]),
            .clock_cnt_i  (clock_cnt_r),
            .done_o       (done_vec[i]),
            .new_done_o   (new_done_vec[i]),
            .done_cycle_o (done_cycle_o[i*cnt_width_lp +: cnt_width_lp]),
            .op_cnt_o     (op_cnt_w[i])
        );
        assign op_cnt_o[i*cnt_width_lp +: cnt_width_lp] = op_cnt_w[i];
    end

    // Pass is decided on the done vector as it will be after this edge, so
    // the final done and the pass flag land together.
    assign all_done_next = &(done_vec | new_done_vec);
    assign progress      = (|activity_i) | (|new_done_vec);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_idle;
            clock_cnt_r <= '0;
            stall_cnt_r <= '0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            finish_r    <= 1'b0;
        end else begin
            finish_r <= 1'b0;
            unique case (state_r)
                e_idle: begin
                    if (!freeze_i) state_r <= e_run;
                end
                e_run: begin
                    if (counting) begin
                        if (clock_cnt_r != max_cnt_lp) clock_cnt_r <= clock_cnt_r + 1'b1;
                        stall_cnt_r <= progress ? '0 : stall_cnt_r + 1'b1;
                        // Completion outranks the watchdog on the same cycle.
                        if (all_done_next) begin
                            state_r  <= e_pass;
                            pass_r   <= 1'b1;
                            finish_r <= 1'b1;
                        end else if ((stall_cnt_r == stall_last_lp) && !progress) begin
                            state_r   <= e_timeout;
                            timeout_r <= 1'b1;
                            finish_r  <= 1'b1;
                        end
                    end
                end
                default: ; // e_pass / e_timeout hold until reset
            endcase
        end
    end

    assign done_vec_o  = done_vec;
    assign clock_cnt_o = clock_cnt_r;
    assign pass_o      = pass_r;
    assign timeout_o   = timeout_r;
    assign finish_o    = finish_r;

    // Bandwidth figures for the end-of-test report.
    logic [63:0] total_bytes;
    logic [63:0] mbpc;

    // NOTE: every variable driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        total_bytes = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            total_bytes = total_bytes + 64'(op_cnt_w[i]) * 64'(bytes_per_op_p);
        end
        mbpc = (clock_cnt_r == '0) ? 64'd0 : (total_bytes * 64'd1000) / 64'(clock_cnt_r);
    end

    always @(negedge clk_i) begin
        if (report_p && finish_r) begin
            if (pass_r) begin
                $display("[monitor] bytes=%0d cycles=%0d mBPC=%0d", total_bytes, clock_cnt_r, mbpc);
                $display("Test PASSed");
            end else begin
                $display("Test FAILed: timeout");
                $display("[monitor] done_vec=%b", done_vec);
            end
        end
    end

endmodule

// File: tb/tb_bp_me_nonsynth_multi_lce_test_monitor.sv
module tb_bp_me_nonsynth_multi_lce_test_monitor;

    localparam int n_lce  = 2;
    localparam int cnt_w  = 30;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic                   freeze_i;
    logic [n_lce-1:0]       tr_done_i;
    logic [n_lce-1:0]       activity_i;
    logic [n_lce-1:0]       done_vec_o;
    logic [cnt_w-1:0]       clock_cnt_o;
    logic [n_lce*cnt_w-1:0] done_cycle_o;
    logic [n_lce*cnt_w-1:0] op_cnt_o;
    logic                   pass_o;
    logic                   timeout_o;
    logic                   finish_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    bp_me_nonsynth_multi_lce_test_monitor #(
        .num_lce_p        (n_lce),
        .max_clock_cnt_p  (2**30 - 1),
        .timeout_cycles_p (16),
        .bytes_per_op_p   (64),
        .report_p         (1'b0)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .freeze_i     (freeze_i),
        .tr_done_i    (tr_done_i),
        .activity_i   (activity_i),
        .done_vec_o   (done_vec_o),
        .clock_cnt_o  (clock_cnt_o),
        .done_cycle_o (done_cycle_o),
        .op_cnt_o     (op_cnt_o),
        .pass_o       (pass_o),
        .timeout_o    (timeout_o),
        .finish_o     (finish_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc(input logic [n_lce-1:0] done, input logic [n_lce-1:0] act);
        tr_done_i  = done;
        activity_i = act;
        step();
        tr_done_i  = '0;
        activity_i = '0;
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        freeze_i   = 1'b1;
        tr_done_i  = '0;
        activity_i = '0;
        step();
        step();
        reset_i = 1'b0;
    endtask

    // Leaves the monitor in e_run with clock_cnt == 0.
    task automatic start_run();
        freeze_i = 1'b0;
        step();
    endtask

    initial begin
        // ---------------- scenario 1: staggered dones ----------------
        do_reset();
        check("rst_done_vec",   done_vec_o,   0);
        check("rst_clock_cnt",  clock_cnt_o,  0);
        check("rst_done_cycle", done_cycle_o, 0);
        check("rst_op_cnt",     op_cnt_o,     0);
        check("rst_pass",       pass_o,       0);
        check("rst_timeout",    timeout_o,    0);
        check("rst_finish",     finish_o,     0);
        for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00);
        // Done on the idle->run edge must be ignored.
        freeze_i = 1'b0;
        cyc(2'b11, 2'b00);
        check("s1_idle_done_ignored", done_vec_o, 0);
        check("s1_run_start_cnt", clock_cnt_o, 0);
        for (int c = 0; c <= 20; c++) begin
            cyc((c == 10) ? 2'b01 : (c == 20) ? 2'b10 : 2'b00,
                (c == 15) ? 2'b01 : 2'b00);
            if (c == 10) check("s1_done0_latched", done_vec_o, 2'b01);
            if (c == 19) check("s1_no_early_pass", pass_o, 0);
        end
        check("s1_pass",       pass_o,      1);
        check("s1_finish",     finish_o,    1);
        check("s1_clock_cnt",  clock_cnt_o, 21);
        check("s1_done_cycle", done_cycle_o, {30'd20, 30'd10});
        check("s1_timeout",    timeout_o,   0);
        cyc(2'b00, 2'b01);
        check("s1_finish_drop", finish_o,   0);
        check("s1_pass_sticky", pass_o,     1);
        check("s1_cnt_frozen",  clock_cnt_o, 21);
        check("s1_op_after_done", op_cnt_o, {30'd0, 30'd1});
        check("s1_done_vec",    done_vec_o, 2'b11);

        // ---------------- scenario 2: pure timeout ----------------
        do_reset();
        start_run();
        for (int c = 0; c < 15; c++) cyc(2'b00, 2'b00);
        check("s2_no_early_timeout", timeout_o, 0);
        cyc(2'b00, 2'b00);
        check("s2_timeout",   timeout_o,   1);
        check("s2_finish",    finish_o,    1);
        check("s2_pass",      pass_o,      0);
        check("s2_clock_cnt", clock_cnt_o, 16);
        cyc(2'b00, 2'b00);
        check("s2_finish_drop",  finish_o,    0);
        check("s2_cnt_frozen",   clock_cnt_o, 16);
        check("s2_timeout_sticky", timeout_o, 1);

        // ---------------- scenario 3: periodic activity ----------------
        do_reset();
        start_run();
        for (int c = 0; c < 100; c++) begin
            cyc(2'b00, {1'(c % 15 == 10), 1'(c % 15 == 0)});
        end
        check("s3_no_timeout", timeout_o, 0);
        check("s3_op_cnt_mid", op_cnt_o, {30'd6, 30'd7});
        cyc(2'b11, 2'b00);
        check("s3_pass",       pass_o,      1);
        check("s3_clock_cnt",  clock_cnt_o, 101);
        check("s3_done_cycle", done_cycle_o, {30'd100, 30'd100});

        // ---------------- scenario 6: reset after pass, rerun ----------------
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("s6_pass_clr",       pass_o,       0);
        check("s6_done_vec_clr",   done_vec_o,   0);
        check("s6_clock_cnt_clr",  clock_cnt_o,  0);
        check("s6_op_cnt_clr",     op_cnt_o,     0);
        check("s6_done_cycle_clr", done_cycle_o, 0);
        freeze_i = 1'b1;
        cyc(2'b00, 2'b00);
        start_run();
        for (int c = 0; c <= 3; c++) cyc((c == 3) ? 2'b11 : 2'b00, 2'b00);
        check("s6_rerun_pass",   pass_o,       1);
        check("s6_rerun_cnt",    clock_cnt_o,  4);
        check("s6_rerun_cycles", done_cycle_o, {30'd3, 30'd3});

        // ---------------- scenario 4: done vs. watchdog tie ----------------
        do_reset();
        start_run();
        for (int c = 0; c <= 15; c++) cyc((c == 15) ? 2'b11 : 2'b00, 2'b00);
        check("s4_pass",       pass_o,      1);
        check("s4_timeout",    timeout_o,   0);
        check("s4_finish",     finish_o,    1);
        check("s4_clock_cnt",  clock_cnt_o, 16);
        check("s4_done_cycle", done_cycle_o, {30'd15, 30'd15});

        // ---------------- scenario 5: freeze mid-run ----------------
        do_reset();
        start_run();
        for (int c = 0; c < 10; c++) cyc(2'b00, 2'b00);
        freeze_i = 1'b1;
        for (int c = 0; c < 50; c++) cyc(2'b00, 2'b01);
        check("s5_frozen_cnt",     clock_cnt_o, 10);
        check("s5_frozen_timeout", timeout_o,   0);
        check("s5_frozen_op_cnt",  op_cnt_o,    0);
        freeze_i = 1'b0;
        for (int c = 0; c < 5; c++) cyc(2'b00, 2'b00);
        check("s5_resume_cnt",   clock_cnt_o, 15);
        check("s5_resume_no_to", timeout_o,   0);
        cyc(2'b00, 2'b00);
        check("s5_timeout",      timeout_o,   1);
        check("s5_final_cnt",    clock_cnt_o, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
